// File: rtl/ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ascon_ctrl_fsm
// Description : Round sequencer for the ASCON AEAD datapath. It covers init,
//               AD blocks, PT blocks and finalisation, at one round per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_ctrl_fsm #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    output logic       en_o,
    output logic       mod_o,
    output logic [3:0] round_o,
    output logic       en_xor_data_o,
    output logic       en_xor_begin_key_o,
    output logic       en_xor_lsb_o,
    output logic       en_xor_end_key_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_A - 1);
    localparam logic [3:0] RB0        = 4'(12 - ROUNDS_B);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        WAIT_AD = 3'd2,
        AD      = 3'd3,
        WAIT_PT = 3'd4,
        PT      = 3'd5,
        FINAL   = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ad_last_q, ad_last_d;
    logic       last_rnd;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ad_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ad_last_q <= ad_last_d;
        end
    end

    assign last_rnd = (cnt_q == LAST_ROUND);

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        ad_last_d          = ad_last_q;
        data_ready_o       = 1'b0;
        en_o               = 1'b0;
        mod_o              = 1'b1;
        round_o            = 4'd0;
        en_xor_data_o      = 1'b0;
        en_xor_begin_key_o = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_xor_end_key_o   = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        done_o             = 1'b0;

        case (state_q)
            IDLE: begin
                // Round 0 runs on the external initial state in the start cycle
                mod_o = 1'b0;
                if (start_i) begin
                    en_o    = 1'b1;
                    state_d = INIT;
                    cnt_d   = 4'd1;
                end
            end
            INIT: begin
                en_o    = 1'b1;
                round_o = cnt_q;
                cnt_d   = cnt_q + 4'd1;
                if (last_rnd) begin
                    en_xor_end_key_o = 1'b1;
                    state_d          = WAIT_AD;
                    cnt_d            = 4'd0;
                end
            end
            WAIT_AD: begin
                data_ready_o = 1'b1;
                round_o      = RB0;
                if (data_valid_i) begin
                    en_o          = 1'b1;
                    en_xor_data_o = 1'b1;
                    ad_last_d     = data_last_i;
                    state_d       = AD;
                    cnt_d         = RB0 + 4'd1;
                end
            end
            AD: begin
                en_o    = 1'b1;
                round_o = cnt_q;
                cnt_d   = cnt_q + 4'd1;
                if (last_rnd) begin
                    cnt_d = 4'd0;
                    if (ad_last_q) begin
                        en_xor_lsb_o = 1'b1;
                        state_d      = WAIT_PT;
                    end else begin
                        state_d = WAIT_AD;
                    end
                end
            end
            WAIT_PT: begin
                data_ready_o = 1'b1;
                round_o      = (data_valid_i && data_last_i) ? 4'd0 : RB0;
                if (data_valid_i) begin
                    en_o          = 1'b1;
                    en_xor_data_o = 1'b1;
                    en_cipher_o   = 1'b1;
                    // The last PT block is absorbed directly into finalisation
                    if (data_last_i) begin
                        en_xor_begin_key_o = 1'b1;
                        state_d            = FINAL;
                        cnt_d              = 4'd1;
                    end else begin
                        state_d = PT;
                        cnt_d   = RB0 + 4'd1;
                    end
                end
            end
            PT: begin
                en_o    = 1'b1;
                round_o = cnt_q;
                cnt_d   = cnt_q + 4'd1;
                if (last_rnd) begin
                    state_d = WAIT_PT;
                    cnt_d   = 4'd0;
                end
            end
            FINAL: begin
                en_o    = 1'b1;
                round_o = cnt_q;
                cnt_d   = cnt_q + 4'd1;
                if (last_rnd) begin
                    en_xor_end_key_o = 1'b1;
                    en_tag_o         = 1'b1;
                    state_d          = DONE;
                    cnt_d            = 4'd0;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_ctrl_fsm
// Description : Directed, table-driven bench for ascon_ctrl_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_ctrl_fsm;

    typedef struct packed {
        logic       ready;
        logic       en;
        logic       mod;
        logic [3:0] round;
        logic       xdata;
        logic       bkey;
        logic       lsb;
        logic       ekey;
        logic       cipher;
        logic       tag;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        logic  start;
        logic  valid;
        logic  last;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic start = 1'b0, valid = 1'b0, last = 1'b0;

    logic       ready, en, mod, xdata, bkey, lsb, ekey, cipher, tag, busy, done;
    logic [3:0] round;
    logic       ready12, en12, mod12, xdata12, bkey12, lsb12, ekey12, cipher12, tag12, busy12, done12;
    logic [3:0] round12;
    outs_t      act;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign act = {ready, en, mod, round, xdata, bkey, lsb, ekey, cipher, tag, busy, done};

    ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(8)) dut (
        .clock_i(clk), .resetb_i(resetb), .start_i(start),
        .data_valid_i(valid), .data_last_i(last),
        .data_ready_o(ready), .en_o(en), .mod_o(mod), .round_o(round),
        .en_xor_data_o(xdata), .en_xor_begin_key_o(bkey), .en_xor_lsb_o(lsb),
        .en_xor_end_key_o(ekey), .en_cipher_o(cipher), .en_tag_o(tag),
        .busy_o(busy), .done_o(done)
    );

    ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(12)) dut12 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start),
        .data_valid_i(valid), .data_last_i(last),
        .data_ready_o(ready12), .en_o(en12), .mod_o(mod12), .round_o(round12),
        .en_xor_data_o(xdata12), .en_xor_begin_key_o(bkey12), .en_xor_lsb_o(lsb12),
        .en_xor_end_key_o(ekey12), .en_cipher_o(cipher12), .en_tag_o(tag12),
        .busy_o(busy12), .done_o(done12)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
        end
    endtask

    task automatic apply(input logic s, input logic v, input logic l);
        start = s;
        valid = v;
        last  = l;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 1'b0);
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 0, 32'(act), 32'd0);
        resetb = 1'b1;
        next_cycle();
    endtask

    // Expected behaviour of the ROUNDS_B=8 single-AD/single-PT flow, with the
    // AD block presented d cycles after WAIT_AD is reached.
    function automatic vec_t flow_vec(int c, int d);
        vec_t v;
        int   b;
        v.start = 1'b0;
        v.valid = 1'b0;
        v.last  = 1'b0;
        v.exp   = '0;
        if (c >= 12 && c < 12 + d) begin
            v.exp.ready = 1'b1;
            v.exp.mod   = 1'b1;
            v.exp.round = 4'd4;
            v.exp.busy  = 1'b1;
            return v;
        end
        b = (c >= 12 + d) ? c - d : c;
        v.start      = (b == 0);
        v.valid      = (b == 12 || b == 20);
        v.last       = v.valid;
        v.exp.ready  = v.valid;
        v.exp.en     = (b <= 31);
        v.exp.mod    = (b >= 1 && b <= 32);
        v.exp.round  = (b <= 11) ? 4'(b) : (b <= 19) ? 4'(b - 8) : (b <= 31) ? 4'(b - 20) : 4'd0;
        v.exp.xdata  = v.valid;
        v.exp.bkey   = (b == 20);
        v.exp.lsb    = (b == 19);
        v.exp.ekey   = (b == 11 || b == 31);
        v.exp.cipher = (b == 20);
        v.exp.tag    = (b == 31);
        v.exp.busy   = (b >= 1 && b <= 32);
        v.exp.done   = (b == 32);
        return v;
    endfunction

    task automatic run_flow(input string name, input int d, input int ncyc);
        vec_t tab[48];
        for (int i = 0; i < ncyc; i++) tab[i] = flow_vec(i, d);
        for (int i = 0; i < ncyc; i++) begin
            apply(tab[i].start, tab[i].valid, tab[i].last);
            @(negedge clk);
            chk(name, i, 32'(act), 32'(tab[i].exp));
            next_cycle();
        end
    endtask

    initial begin
        int hs, lsb_cnt, lsb_hs, cip_cnt, bkey_cnt, bkey_hs, tag_cnt, done_cnt, done_cyc, en_cnt, viol;
        logic [3:0] exp_r;

        // Basic flow and delayed-AD flow
        do_reset();
        run_flow("flow", 0, 34);
        do_reset();
        run_flow("flow_wait5", 5, 39);

        // Reset in the middle of FINAL, then a clean restart
        do_reset();
        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v = flow_vec(i, 0);
            apply(v.start, v.valid, v.last);
            next_cycle();
        end
        apply(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("in_final_busy", 0, 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        resetb = 1'b0;
        #1;
        chk("midreset_busy", 0, 32'(busy), 32'd0);
        chk("midreset_en", 0, 32'(en), 32'd0);
        chk("midreset_round", 0, 32'(round), 32'd0);
        chk("midreset_mod", 0, 32'(mod), 32'd0);
        @(negedge clk);
        resetb = 1'b1;
        next_cycle();
        run_flow("flow_after_reset", 0, 34);

        // 2 AD + 3 PT blocks, valid held high from start, stray start pulses
        do_reset();
        hs = 0; lsb_cnt = 0; lsb_hs = -1; cip_cnt = 0; bkey_cnt = 0; bkey_hs = -1;
        tag_cnt = 0; done_cnt = 0; done_cyc = -1; en_cnt = 0; viol = 0;
        for (int c = 0; c < 80; c++) begin
            apply((c == 0) || (c >= 3 && c <= 6) || (hs == 3), (hs < 5), (hs == 1) || (hs == 4));
            @(negedge clk);
            if (c >= 1 && c <= 11) chk("init_no_hs", c, 32'({ready, xdata}), 32'd0);
            if (lsb && ekey) viol++;
            if (bkey && !xdata) viol++;
            if (lsb) begin lsb_cnt++; lsb_hs = hs; end
            if (bkey) begin bkey_cnt++; bkey_hs = hs; end
            if (cipher) cip_cnt++;
            if (tag) tag_cnt++;
            if (en) en_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (ready && valid) hs++;
            next_cycle();
        end
        chk("multi_hs", 0, 32'(hs), 32'd5);
        chk("multi_lsb_cnt", 0, 32'(lsb_cnt), 32'd1);
        chk("multi_lsb_after_ad2", 0, 32'(lsb_hs), 32'd2);
        chk("multi_cipher_cnt", 0, 32'(cip_cnt), 32'd3);
        chk("multi_bkey_cnt", 0, 32'(bkey_cnt), 32'd1);
        chk("multi_bkey_pt3", 0, 32'(bkey_hs), 32'd4);
        chk("multi_tag_cnt", 0, 32'(tag_cnt), 32'd1);
        chk("multi_done_cnt", 0, 32'(done_cnt), 32'd1);
        chk("multi_done_cycle", 0, 32'(done_cyc), 32'd56);
        chk("multi_en_cnt", 0, 32'(en_cnt), 32'd56);
        chk("multi_xor_rules", 0, 32'(viol), 32'd0);

        // ROUNDS_B = 12 instance: data permutations run rounds 0..11
        do_reset();
        for (int c = 0; c < 40; c++) begin
            apply(c == 0, (c == 12 || c == 24), (c == 12 || c == 24));
            @(negedge clk);
            exp_r = (c <= 11) ? 4'(c) : (c <= 23) ? 4'(c - 12) : (c <= 35) ? 4'(c - 24) : 4'd0;
            chk("rb12", c, 32'({en12, round12, lsb12, done12}),
                32'({(c <= 35), exp_r, (c == 23), (c == 36)}));
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
